// File: rtl/altro_cmd_arb.sv
`timescale 1ns/1ps
// altro_cmd_arb: round-robin arbiter and sequencer for the ALTRO single-command
// channel. Port 0 is the DCS slow-control decoder, port 1 the configuration loader.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no command in flight; arbitrate eligible requests
// WAIT    | command issued; waiting for acmd_ack or watchdog expiry
// RELEASE | completion reported; waiting for acmd_ack to drop
module altro_cmd_arb #(
  parameter int              TO_W    = 17,
  parameter logic [TO_W-1:0] TIMEOUT = 17'd70000
) (
  input  logic        rdoclk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_rw,
  input  logic [19:0] req0_addr,
  input  logic [19:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic        req0_err,
  output logic [19:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_rw,
  input  logic [19:0] req1_addr,
  input  logic [19:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic        req1_err,
  output logic [19:0] req1_rdata,
  output logic        acmd_exec,
  output logic        acmd_rw,
  output logic [19:0] acmd_addr,
  output logic [19:0] acmd_rx,
  input  logic [19:0] acmd_tx,
  input  logic        acmd_ack,
  input  logic        rdo_active,
  output logic        busy,
  output logic [7:0]  err_cnt,
  output logic [15:0] cmd_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] WD_LOAD = TO_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic            cur_port;
  logic [TO_W-1:0] wd_cnt;
  logic            wd_tc;

  logic            elig0;
  logic            elig1;
  logic            grant_any;
  logic            grant_sel;
  logic            sel_rw;
  logic [19:0]     sel_addr;
  logic [19:0]     sel_wdata;

  logic            do_issue;
  logic            do_reject;
  logic            do_accept;
  logic            cmpl_ack;
  logic            cmpl_to;
  logic            cmpl_any;

  // A ready pulse still high means the requester has not yet seen its accept,
  // so its valid is stale for this edge and must not be granted again.
  assign elig0     = req0_valid & ~rdo_active & ~req0_ready;
  assign elig1     = req1_valid & ~rdo_active & ~req1_ready;
  assign wd_tc     = (wd_cnt == '0);
  assign do_accept = do_issue | do_reject;
  assign cmpl_any  = cmpl_ack | cmpl_to;

  // Round-robin grant selection and operand mux for the granted port.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    if (elig0 && elig1) begin
      grant_any = 1'b1;
      grant_sel = ~last_grant;
    end else if (elig0) begin
      grant_any = 1'b1;
      grant_sel = 1'b0;
    end else if (elig1) begin
      grant_any = 1'b1;
      grant_sel = 1'b1;
    end
    sel_rw    = grant_sel ? req1_rw    : req0_rw;
    sel_addr  = grant_sel ? req1_addr  : req0_addr;
    sel_wdata = grant_sel ? req1_wdata : req0_wdata;
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    state_nxt = state;
    do_issue  = 1'b0;
    do_reject = 1'b0;
    cmpl_ack  = 1'b0;
    cmpl_to   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          if (sel_rw && sel_addr[18]) begin
            do_reject = 1'b1;
          end else begin
            do_issue  = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (acmd_ack) begin
          cmpl_ack  = 1'b1;
          state_nxt = RELEASE;
        end else if (wd_tc) begin
          cmpl_to   = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!acmd_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy follows the registered state.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Watchdog: loaded at issue, counts down in WAIT, expires at zero.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (do_issue) begin
      wd_cnt <= WD_LOAD;
    end else if (state == WAIT && !wd_tc) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  // Arbitration history and owner of the command in flight.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      cur_port   <= 1'b0;
    end else begin
      if (do_accept) last_grant <= grant_sel;
      if (do_issue)  cur_port   <= grant_sel;
    end
  end

  // Command operands toward the ALTRO bus interface, held between issues.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      acmd_exec <= 1'b0;
      acmd_rw   <= 1'b0;
      acmd_addr <= '0;
      acmd_rx   <= '0;
    end else begin
      acmd_exec <= do_issue;
      if (do_issue) begin
        acmd_rw   <= sel_rw;
        acmd_addr <= sel_addr;
        acmd_rx   <= sel_wdata;
      end
    end
  end

  // Port 0 handshake and completion status.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      req0_ready <= 1'b0;
      req0_done  <= 1'b0;
      req0_err   <= 1'b0;
      req0_rdata <= '0;
    end else begin
      req0_ready <= do_accept & ~grant_sel;
      req0_done  <= (do_reject & ~grant_sel) | (cmpl_any & ~cur_port);
      if (do_reject && !grant_sel) begin
        req0_err <= 1'b1;
      end else if (cmpl_any && !cur_port) begin
        req0_err <= cmpl_to;
      end
      if (cmpl_ack && !cur_port) req0_rdata <= acmd_tx;
    end
  end

  // Port 1 handshake and completion status.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      req1_ready <= 1'b0;
      req1_done  <= 1'b0;
      req1_err   <= 1'b0;
      req1_rdata <= '0;
    end else begin
      req1_ready <= do_accept & grant_sel;
      req1_done  <= (do_reject & grant_sel) | (cmpl_any & cur_port);
      if (do_reject && grant_sel) begin
        req1_err <= 1'b1;
      end else if (cmpl_any && cur_port) begin
        req1_err <= cmpl_to;
      end
      if (cmpl_ack && cur_port) req1_rdata <= acmd_tx;
    end
  end

  // Statistics: saturating error count, wrapping issue count.
  always_ff @(posedge rdoclk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
      cmd_cnt <= '0;
    end else begin
      if ((do_reject || cmpl_to) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (do_issue) cmd_cnt <= cmd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_altro_cmd_arb.sv
`timescale 1ns/1ps
// tb_altro_cmd_arb: directed scenarios plus a randomized soak, every cycle
// compared against a transaction-level reference of the arbiter.
module tb_altro_cmd_arb;

  localparam int TO = 100;

  typedef struct packed {
    logic        rw;
    logic [19:0] addr;
    logic [19:0] wdata;
  } req_t;

  logic        rdoclk = 1'b0;
  logic        reset  = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_rw = 1'b0, req1_rw = 1'b0;
  logic [19:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
  logic [19:0] req0_rdata, req1_rdata;
  logic        acmd_exec, acmd_rw;
  logic [19:0] acmd_addr, acmd_rx;
  logic [19:0] acmd_tx = '0;
  logic        acmd_ack = 1'b0;
  logic        rdo_active = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;
  logic [15:0] cmd_cnt;

  altro_cmd_arb #(.TO_W(17), .TIMEOUT(17'd100)) dut (
    .rdoclk(rdoclk), .reset(reset),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .acmd_exec(acmd_exec), .acmd_rw(acmd_rw), .acmd_addr(acmd_addr), .acmd_rx(acmd_rx),
    .acmd_tx(acmd_tx), .acmd_ack(acmd_ack), .rdo_active(rdo_active),
    .busy(busy), .err_cnt(err_cnt), .cmd_cnt(cmd_cnt)
  );

  initial forever #5 rdoclk = ~rdoclk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  e_ready, e_done, e_err;
  logic [19:0] e_rdata [2];
  logic        e_exec, e_rw, e_busy;
  logic [19:0] e_addr, e_rx;
  logic [7:0]  e_errcnt;
  logic [15:0] e_cmdcnt;
  int          m_last, m_owner, m_age;
  bit          m_inflight, m_draining;

  task automatic model_reset();
    e_ready = '0; e_done = '0; e_err = '0;
    e_rdata[0] = '0; e_rdata[1] = '0;
    e_exec = 0; e_rw = 0; e_busy = 0; e_addr = '0; e_rx = '0;
    e_errcnt = '0; e_cmdcnt = '0;
    m_last = 1; m_owner = 0; m_age = 0; m_inflight = 0; m_draining = 0;
  endtask

  // Predicts the outputs after the next rising edge from the inputs now driven.
  task automatic model_step();
    logic [1:0] was_ready;
    bit ok0, ok1;
    int pick;
    req_t r;
    if (reset) begin
      model_reset();
      return;
    end
    was_ready = e_ready;
    e_ready = '0; e_done = '0; e_exec = 0;
    if (!m_inflight && !m_draining) begin
      ok0 = req0_valid && !rdo_active && !was_ready[0];
      ok1 = req1_valid && !rdo_active && !was_ready[1];
      if (ok0 || ok1) begin
        pick = (ok0 && ok1) ? 1 - m_last : (ok0 ? 0 : 1);
        m_last = pick;
        r = pick ? {req1_rw, req1_addr, req1_wdata} : {req0_rw, req0_addr, req0_wdata};
        e_ready[pick] = 1;
        if (r.rw && r.addr[18]) begin
          e_done[pick] = 1;
          e_err[pick]  = 1;
          if (e_errcnt != 8'hFF) e_errcnt++;
        end else begin
          e_exec = 1; e_rw = r.rw; e_addr = r.addr; e_rx = r.wdata;
          e_cmdcnt++;
          m_inflight = 1; m_age = 0; m_owner = pick;
        end
      end
    end else if (m_inflight) begin
      if (acmd_ack) begin
        e_rdata[m_owner] = acmd_tx;
        e_done[m_owner]  = 1;
        e_err[m_owner]   = 0;
        m_inflight = 0; m_draining = 1;
      end else if (m_age == TO - 1) begin
        e_done[m_owner] = 1;
        e_err[m_owner]  = 1;
        if (e_errcnt != 8'hFF) e_errcnt++;
        m_inflight = 0; m_draining = 1;
      end else begin
        m_age++;
      end
    end else if (!acmd_ack) begin
      m_draining = 0;
    end
    e_busy = m_inflight || m_draining;
  endtask

  // ---------------- stimulus agents ----------------
  req_t q0[$], q1[$];
  bit   rand_mode = 0;
  bit   ack_off   = 0;
  bit   tx_fixed_en = 0;
  logic [19:0] tx_fixed = '0;
  int   dmin = 0, dmax = 2, lmin = 1, lmax = 3, drop_pct = 0;
  int   rsp_wait = 0, rsp_len = 0;

  function automatic req_t rand_req();
    req_t r;
    r.addr  = 20'($urandom);
    r.wdata = 20'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      r.rw = 1'b1; r.addr[18] = 1'b1;
    end else begin
      r.rw = 1'($urandom);
      if (r.rw) r.addr[18] = 1'b0;
    end
    return r;
  endfunction

  task automatic present();
    if (rand_mode) begin
      if ($urandom_range(0, 11) == 0) rdo_active = ~rdo_active;
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_req());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_req());
    end
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (req0_valid) {req0_rw, req0_addr, req0_wdata} = q0[0];
    else {req0_rw, req0_addr, req0_wdata} = 41'($urandom);
    if (req1_valid) {req1_rw, req1_addr, req1_wdata} = q1[0];
    else {req1_rw, req1_addr, req1_wdata} = 41'($urandom);
  endtask

  task automatic compare_all();
    check_val("ctrl", {23'd0, req1_ready, req0_ready, req1_done, req0_done, req1_err, req0_err,
                       acmd_exec, busy, acmd_rw},
              {23'd0, e_ready, e_done, e_err, e_exec, e_busy, e_rw});
    check_val("acmd_addr", {12'd0, acmd_addr}, {12'd0, e_addr});
    check_val("acmd_rx", {12'd0, acmd_rx}, {12'd0, e_rx});
    check_val("rdata0", {12'd0, req0_rdata}, {12'd0, e_rdata[0]});
    check_val("rdata1", {12'd0, req1_rdata}, {12'd0, e_rdata[1]});
    check_val("err_cnt", {24'd0, err_cnt}, {24'd0, e_errcnt});
    check_val("cmd_cnt", {16'd0, cmd_cnt}, {16'd0, e_cmdcnt});
  endtask

  // One clock: drive inputs, predict, then compare at the falling edge.
  task automatic tick();
    present();
    model_step();
    @(negedge rdoclk);
    cyc++;
    compare_all();
    if (e_ready[0] && q0.size() > 0) void'(q0.pop_front());
    if (e_ready[1] && q1.size() > 0) void'(q1.pop_front());
    if (e_exec && !ack_off) begin
      rsp_wait = $urandom_range(dmin, dmax);
      rsp_len  = ($urandom_range(1, 100) <= drop_pct) ? 0 : $urandom_range(lmin, lmax);
    end
    if (rsp_len > 0) begin
      if (rsp_wait > 0) begin
        acmd_ack = 1'b0; rsp_wait--;
      end else begin
        acmd_ack = 1'b1; rsp_len--;
      end
    end else begin
      acmd_ack = 1'b0;
    end
    acmd_tx = tx_fixed_en ? tx_fixed : 20'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete();
    rsp_len = 0; rsp_wait = 0; acmd_ack = 1'b0;
    rdo_active = 1'b0; ack_off = 0; tx_fixed_en = 0;
    dmin = 0; dmax = 2; lmin = 1; lmax = 3; drop_pct = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int n_exec, n_done0, n_done1, t_exec, t_done, overlap, bad_port, n_rdy;
  bit seen;
  logic [19:0] cap_addr, cap_rx;
  logic cap_rw, cap_err;
  int order[$];
  int fifo[$];

  initial begin
    model_reset();

    // Reset state and single write with a 5-cycle ack.
    do_reset();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    lmin = 5; lmax = 5; dmin = 1; dmax = 1;
    q0.push_back('{rw: 1'b0, addr: 20'h00A0B, wdata: 20'h12345});
    n_exec = 0; n_done0 = 0; cap_err = 1'bx;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acmd_exec) begin
        n_exec++; cap_addr = acmd_addr; cap_rx = acmd_rx; cap_rw = acmd_rw;
      end
      if (req0_done) begin n_done0++; cap_err = req0_err; end
    end
    check_val("t1_exec_cnt", n_exec, 1);
    check_val("t1_addr", {12'd0, cap_addr}, 32'h00A0B);
    check_val("t1_rx", {12'd0, cap_rx}, 32'h12345);
    check_val("t1_rw", {31'd0, cap_rw}, 32'd0);
    check_val("t1_done_cnt", n_done0, 1);
    check_val("t1_err", {31'd0, cap_err}, 32'd0);
    check_val("t1_cmd_cnt", {16'd0, cmd_cnt}, 32'd1);

    // Simultaneous requests, three per port.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{rw: 1'b0, addr: 20'h00100 + 20'(i), wdata: 20'($urandom)});
      q1.push_back('{rw: 1'b0, addr: 20'h00200 + 20'(i), wdata: 20'($urandom)});
    end
    order.delete(); fifo.delete();
    n_done0 = 0; n_done1 = 0; overlap = 0; bad_port = 0;
    for (int i = 0; i < 200 && (n_done0 + n_done1) < 6; i++) begin
      tick();
      if (req0_ready) order.push_back(0);
      if (req1_ready) order.push_back(1);
      if (acmd_exec) begin
        if (fifo.size() > 0) overlap++;
        fifo.push_back(req1_ready ? 1 : 0);
      end
      if (req0_done || req1_done) begin
        if (fifo.size() == 0 || fifo[0] != (req1_done ? 1 : 0)) bad_port++;
        if (fifo.size() > 0) void'(fifo.pop_front());
        if (req0_done) n_done0++;
        if (req1_done) n_done1++;
      end
    end
    check_val("t2_grants", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) check_val("t2_order", order[i], i % 2);
    check_val("t2_overlap", overlap, 0);
    check_val("t2_done_port", bad_port, 0);
    check_val("t2_done0", n_done0, 3);
    check_val("t2_done1", n_done1, 3);

    // Read on port 1 returning a fixed word.
    do_reset();
    tx_fixed_en = 1; tx_fixed = 20'hABCDE; dmin = 2; dmax = 2; lmin = 1; lmax = 1;
    q1.push_back('{rw: 1'b1, addr: 20'h00123, wdata: 20'h0});
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (req1_done) begin
        seen = 1;
        check_val("t3_rdata", {12'd0, req1_rdata}, 32'hABCDE);
        check_val("t3_err", {31'd0, req1_err}, 32'd0);
      end
    end
    check_val("t3_done_seen", {31'd0, seen}, 32'd1);

    // No ack: watchdog completion after exactly TIMEOUT cycles.
    do_reset();
    ack_off = 1;
    q0.push_back('{rw: 1'b0, addr: 20'h00055, wdata: 20'h00AAA});
    t_exec = -1; t_done = -1;
    for (int i = 0; i < 150 && t_done < 0; i++) begin
      tick();
      if (acmd_exec) t_exec = cyc;
      if (req0_done) begin
        t_done = cyc;
        check_val("t4_err", {31'd0, req0_err}, 32'd1);
        check_val("t4_err_cnt", {24'd0, err_cnt}, 32'd1);
      end
    end
    check_val("t4_latency", t_done - t_exec, TO);
    for (int i = 0; i < 3; i++) tick();
    check_val("t4_idle", {31'd0, busy}, 32'd0);

    // Broadcast read is rejected in a single cycle.
    do_reset();
    q1.push_back('{rw: 1'b1, addr: 20'h40010, wdata: 20'h0});
    n_exec = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acmd_exec) n_exec++;
      if (req1_ready) begin
        seen = 1;
        check_val("t5_done", {31'd0, req1_done}, 32'd1);
        check_val("t5_err", {31'd0, req1_err}, 32'd1);
      end
    end
    check_val("t5_ready_seen", {31'd0, seen}, 32'd1);
    check_val("t5_no_exec", n_exec, 0);
    check_val("t5_err_cnt", {24'd0, err_cnt}, 32'd1);

    // Readout active blocks accepts; release allows one on the next edge.
    do_reset();
    rdo_active = 1'b1;
    q0.push_back('{rw: 1'b0, addr: 20'h00777, wdata: 20'h01234});
    n_rdy = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (req0_ready) n_rdy++;
    end
    check_val("t6_blocked", n_rdy, 0);
    rdo_active = 1'b0;
    tick();
    check_val("t6_accept", {31'd0, req0_ready}, 32'd1);
    for (int i = 0; i < 15; i++) tick();

    // Asynchronous reset during WAIT.
    do_reset();
    ack_off = 1;
    q0.push_back('{rw: 1'b0, addr: 20'h00321, wdata: 20'h00F0F});
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (acmd_exec) seen = 1;
    end
    check_val("t7_exec_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    q0.delete();
    reset = 1'b1;
    #1;
    check_val("t7_arst_ctrl", {23'd0, req1_ready, req0_ready, req1_done, req0_done, req1_err,
                               req0_err, acmd_exec, busy, acmd_rw}, 32'd0);
    check_val("t7_arst_addr", {12'd0, acmd_addr}, 32'd0);
    check_val("t7_arst_cmd_cnt", {16'd0, cmd_cnt}, 32'd0);
    do_reset();
    q0.push_back('{rw: 1'b0, addr: 20'h00999, wdata: 20'h00111});
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req0_ready && acmd_exec) seen = 1;
    end
    check_val("t7_regrant", {31'd0, seen}, 32'd1);

    // Error counter saturation through repeated rejects.
    do_reset();
    for (int i = 0; i < 260; i++) q0.push_back('{rw: 1'b1, addr: 20'h40000 | 20'(i), wdata: 20'h0});
    for (int i = 0; i < 700 && q0.size() > 0; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    check_val("t8_sat", {24'd0, err_cnt}, 32'hFF);

    // Randomized soak with readout gating, slow acks and dropped acks.
    do_reset();
    dmin = 0; dmax = 4; lmin = 1; lmax = 5; drop_pct = 4;
    rand_mode = 1;
    for (int i = 0; i < 2500; i++) tick();
    rand_mode = 0;
    rdo_active = 1'b0;
    for (int i = 0; i < 400 && (q0.size() > 0 || q1.size() > 0 || busy); i++) tick();
    check_val("t9_drained", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
